// File: rtl/implode_arbiter.sv
// Round-robin arbiter granting NUM_REQ hash lanes access to one shared implode loader/engine.
// Optional WAIT_DONE watchdog is compiled in with IMPLODE_ARB_WATCHDOG_EN.
module implode_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int nonce_width    = 7,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*nonce_width-1:0] i_nonce,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic [nonce_width-1:0]         o_nonce,
    output logic                           o_nonce_valid,
    input  logic                           i_ready,
    input  logic                           i_implode_done,
    output logic [NUM_REQ-1:0]             o_done,
    output logic                           o_busy,
    output logic                           o_timeout
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [nonce_width-1:0] nonce_q, nonce_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   wd_expire;

    logic                   found;
    logic [PTR_W-1:0]       sel;
    int                     rr_idx;

`ifdef IMPLODE_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
    assign wd_expire = (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expire = 1'b0;
`endif

    // First requesting lane at or after rr_ptr, wrapping past NUM_REQ-1 to lane 0.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        rr_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = int'(rr_ptr_q) + i;
            if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
            if (!found && i_req[rr_idx]) begin
                found = 1'b1;
                sel   = PTR_W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        nonce_d  = nonce_q;
        valid_d  = 1'b0;
        done_d   = '0;
`ifdef IMPLODE_ARB_WATCHDOG_EN
        wd_cnt_d  = '0;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = ISSUE;
                    grant_d  = NUM_REQ'(1) << sel;
                    nonce_d  = i_nonce[int'(sel)*nonce_width +: nonce_width];
                    rr_ptr_d = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);
                    valid_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (i_ready) state_d = WAIT_DONE;
                else         valid_d = 1'b1;
            end
            WAIT_DONE: begin
                // A real done in the expiry cycle wins over the watchdog.
                if (i_implode_done || wd_expire) begin
                    state_d = RELEASE;
                    done_d  = grant_q;
`ifdef IMPLODE_ARB_WATCHDOG_EN
                    timeout_d = !i_implode_done;
`endif
                end else begin
`ifdef IMPLODE_ARB_WATCHDOG_EN
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
`endif
                end
            end
            RELEASE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            nonce_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= '0;
            busy_q   <= 1'b0;
`ifdef IMPLODE_ARB_WATCHDOG_EN
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            nonce_q  <= nonce_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef IMPLODE_ARB_WATCHDOG_EN
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_grant       = grant_q;
    assign o_nonce       = nonce_q;
    assign o_nonce_valid = valid_q;
    assign o_done        = done_q;
    assign o_busy        = busy_q;
`ifdef IMPLODE_ARB_WATCHDOG_EN
    assign o_timeout     = timeout_q;
`else
    assign o_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_implode_arbiter.sv
// Bench for implode_arbiter: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model of the arbitration and loader handshake.
module tb_implode_arbiter;
    localparam int N  = 4;
    localparam int NW = 7;
    localparam int TO = 16;
`ifdef IMPLODE_ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    i_req;
    logic [N*NW-1:0] i_nonce;
    logic [N-1:0]    o_grant;
    logic [NW-1:0]   o_nonce;
    logic            o_nonce_valid;
    logic            i_ready;
    logic            i_implode_done;
    logic [N-1:0]    o_done;
    logic            o_busy;
    logic            o_timeout;

    implode_arbiter #(.NUM_REQ(N), .nonce_width(NW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn), .i_req(i_req), .i_nonce(i_nonce),
        .o_grant(o_grant), .o_nonce(o_nonce), .o_nonce_valid(o_nonce_valid),
        .i_ready(i_ready), .i_implode_done(i_implode_done), .o_done(o_done),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 nonce offered, 2 engine running, 3 completion cycle.
    int            m_phase;
    int            m_lane;
    int            m_ptr;
    int            m_wd;
    bit            m_to;
    logic [NW-1:0] m_nonce;

    function automatic void model_reset();
        m_phase = 0; m_lane = 0; m_ptr = 0; m_wd = 0; m_to = 1'b0; m_nonce = '0;
    endfunction

    function automatic void model_step(input logic [N-1:0] req, input logic rdy,
                                       input logic dn, input logic [N*NW-1:0] nonces);
        case (m_phase)
            0: begin
                for (int k = 0; k < N; k++) begin
                    int l;
                    l = (m_ptr + k) % N;
                    if (m_phase == 0 && req[l]) begin
                        m_lane  = l;
                        m_nonce = nonces[l*NW +: NW];
                        m_ptr   = (l + 1) % N;
                        m_phase = 1;
                    end
                end
            end
            1: if (rdy) begin m_phase = 2; m_wd = 0; end
            2: begin
                if (dn) begin
                    m_phase = 3; m_to = 1'b0;
                end else begin
                    m_wd++;
                    if (WD_EN && m_wd == TO) begin m_phase = 3; m_to = 1'b1; end
                end
            end
            default: m_phase = 0;
        endcase
    endfunction

    task automatic compare_all();
        logic [31:0] eg;
        eg = (m_phase != 0) ? (32'd1 << m_lane) : 32'd0;
        chk("grant",   32'(o_grant),       eg);
        chk("nonce",   32'(o_nonce),       32'(m_nonce));
        chk("valid",   32'(o_nonce_valid), 32'(m_phase == 1));
        chk("done",    32'(o_done),        (m_phase == 3) ? eg : 32'd0);
        chk("busy",    32'(o_busy),        32'(m_phase != 0));
        chk("timeout", 32'(o_timeout),     32'(m_phase == 3 && m_to));
    endtask

    // Inputs change on the falling edge; the model consumes them at the rising edge.
    task automatic step(input logic [N-1:0] req, input logic rdy, input logic dn);
        i_req = req; i_ready = rdy; i_implode_done = dn;
        @(posedge clk);
        model_step(req, rdy, dn, i_nonce);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_txn(input logic [N-1:0] req, input int exp_lane,
                           input int rdy_dly, input int done_dly);
        step(req, 1'b0, 1'b0);
        if (exp_lane >= 0) chk("rr_order", 32'(o_grant), 32'd1 << exp_lane);
        repeat (rdy_dly) step(req, 1'b0, 1'b0);
        step(req, 1'b1, 1'b0);
        repeat (done_dly) step(req, 1'b0, 1'b0);
        step(req, 1'b0, 1'b1);
        step(req, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(o_grant), 0);
        chk({tag, "_nonce"}, 32'(o_nonce), 0);
        chk({tag, "_valid"}, 32'(o_nonce_valid), 0);
        chk({tag, "_done"},  32'(o_done), 0);
        chk({tag, "_busy"},  32'(o_busy), 0);
        chk({tag, "_tmo"},   32'(o_timeout), 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check_all_zero("rst");
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [NW-1:0] n0;
        rstn = 1'b1; i_req = '0; i_ready = 1'b0; i_implode_done = 1'b0;
        i_nonce = 28'($urandom);
        @(negedge clk);
        do_reset();

        // Single request on lane 0, nonce 0x15, ready two cycles after valid.
        n0 = 7'h15;
        i_nonce[0 +: NW] = n0;
        step(4'b0001, 1'b0, 1'b0);
        chk("single_grant", 32'(o_grant), 32'h1);
        chk("single_nonce", 32'(o_nonce), 32'h15);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        repeat (9) step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        chk("single_done", 32'(o_done), 32'h1);
        step(4'b0000, 1'b0, 1'b0);
        chk("single_idle", 32'(o_busy), 0);

        // Fairness with all lanes held high from a fresh reset.
        do_reset();
        for (int k = 0; k < 5; k++) run_txn(4'b1111, k % N, k % 3, k + 1);

        // Lane 2 drops its request mid-operation while others start requesting.
        do_reset();
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        repeat (3) step(4'b1011, 1'b0, 1'b0);
        step(4'b1011, 1'b0, 1'b1);
        chk("drop_done", 32'(o_done), 32'h4);
        step(4'b1011, 1'b0, 1'b0);

        // Spurious done pulses in IDLE and in ISSUE.
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b1);
        chk("spur_valid", 32'(o_nonce_valid), 1);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);

        // Reset in the middle of WAIT_DONE; arbitration restarts at lane 0.
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        do_reset();
        run_txn(4'b1111, 0, 0, 2);

        // Engine never finishes.
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        repeat (TO - 1) step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        if (WD_EN) begin
            chk("wd_timeout", 32'(o_timeout), 1);
            chk("wd_done", 32'(o_done), 32'h4);
            step(4'b0000, 1'b0, 1'b0);
        end else begin
            repeat (20) step(4'b0000, 1'b0, 1'b0);
            chk("wd_stay", 32'(o_busy), 1);
            step(4'b0000, 1'b0, 1'b1);
            step(4'b0000, 1'b0, 1'b0);
        end

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) i_nonce = 28'($urandom);
            step(4'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/implode_arbiter.md
IMPLODE_ARBITER -- requirements
Module: implode_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of hash lanes sharing one implode loader/engine (2..8).
REQ-002 SHALL have parameter nonce_width, default 7: width of the per-lane nonce.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit for WAIT_DONE, in cycles.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_req  input  NUM_REQ  per-lane level request; the lane's state is ready in the shared BRAM.
REQ-007 SHALL have port i_nonce  input  NUM_REQ*nonce_width  per-lane nonce; lane k occupies bits [k*nonce_width +: nonce_width].
REQ-008 SHALL have port o_grant  output  NUM_REQ  one-hot grant, or all zero.
REQ-009 SHALL have port o_nonce  output  nonce_width  nonce of the granted lane, registered.
REQ-010 SHALL have port o_nonce_valid  output  1  nonce-valid toward the loader.
REQ-011 SHALL have port i_ready  input  1  loader acknowledge; high once the loader has captured the nonce.
REQ-012 SHALL have port i_implode_done  input  1  single-cycle implode-complete pulse.
REQ-013 SHALL have port o_done  output  NUM_REQ  one-cycle completion pulse to the granted lane.
REQ-014 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port o_timeout  output  1  one-cycle watchdog pulse; constant 0 when the watchdog is compiled out.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT_DONE and RELEASE.
REQ-017 IDLE: if any i_req is high, SHALL select a lane by round-robin starting at pointer rr_ptr, register o_grant and o_nonce, and move to ISSUE.
REQ-018 On selection, SHALL set rr_ptr = (selected+1) mod NUM_REQ.
REQ-019 ISSUE: o_nonce_valid SHALL be high. When i_ready is sampled high, SHALL drop o_nonce_valid on the next cycle and move to WAIT_DONE.
REQ-020 WAIT_DONE: on i_implode_done, SHALL move to RELEASE.
REQ-021 RELEASE: SHALL assert o_done[granted] for exactly one cycle, clear o_grant and return to IDLE.
REQ-022 Latency: i_req high in IDLE SHALL give o_nonce_valid high on the next cycle.
REQ-023 Minimum spacing between o_done and the next o_nonce_valid SHALL be 2 cycles.
REQ-024 o_grant and o_nonce SHALL stay stable from ISSUE through RELEASE.
REQ-025 Deassertion of the granted lane's i_req mid-operation SHALL be ignored; the operation completes.
REQ-026 i_implode_done in IDLE or ISSUE SHALL be ignored.
REQ-027 Requests arriving during ISSUE, WAIT_DONE or RELEASE SHALL wait; no request SHALL be lost while held high.
REQ-028 Pointer wrap: NUM_REQ-1 SHALL be followed by lane 0.

Reset
REQ-029 While rstn is low, SHALL force state IDLE, rr_ptr=0, o_grant=0, o_nonce=0, o_nonce_valid=0, o_done=0, o_busy=0, o_timeout=0 and watchdog count=0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL abort immediately with no o_done pulse.
REQ-031 After reset release, arbitration SHALL restart from lane 0.

Configuration
REQ-032 SHALL use macro IMPLODE_ARB_WATCHDOG_EN to compile the watchdog in or out.
REQ-033 With IMPLODE_ARB_WATCHDOG_EN defined: SHALL count cycles in WAIT_DONE; when the count reaches TIMEOUT_CYCLES with no done, SHALL move to RELEASE, pulse o_timeout together with o_done, and clear the count on leaving WAIT_DONE.
REQ-034 Without IMPLODE_ARB_WATCHDOG_EN: SHALL contain no counter, o_timeout SHALL be tied 0, and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-035 Single request: i_req=0001, nonce0=0x15, i_ready two cycles after valid, done 10 cycles later -> o_grant=0001, o_nonce=0x15, o_done=0001 one cycle, back to IDLE.
REQ-036 Fairness: i_req=1111 held -> grants in order 0001, 0010, 0100, 1000, 0001.
REQ-037 Request drop: lane 2 granted, i_req[2] dropped during WAIT_DONE -> o_done[2] still pulses; no other grant before RELEASE.
REQ-038 Spurious done: i_implode_done pulsed in IDLE and in ISSUE -> no state change, no o_done.
REQ-039 Reset mid-WAIT_DONE: rstn low asynchronously -> all outputs 0 immediately; next grant goes to lane 0 when i_req=1111.
REQ-040 Watchdog (macro defined, TIMEOUT_CYCLES=16): no done -> 16 cycles into WAIT_DONE, o_timeout and o_done[granted] pulse together. Without the macro, the design stays in WAIT_DONE.
